// File: rtl/mips_pkg.sv
// Shared definitions for the MEM pipeline stage: access-size encodings,
// FSM state type, default wait-state count and an alignment helper.
package mips_pkg;

  localparam logic [1:0] SIZE_BYTE    = 2'd0;
  localparam logic [1:0] SIZE_HALF    = 2'd1;
  localparam logic [1:0] SIZE_WORD    = 2'd2;
  localparam logic [1:0] SIZE_ILLEGAL = 2'd3;

  localparam int WAIT_CYC_DEFAULT = 2;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  // True when the low address bits do not suit the (already legalised) size.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = addr_lo[0];
      default:   mis = |addr_lo;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/data_mem_stage_if.sv
// EX/MEM inputs, the stall back-pressure and the MEM/WB register outputs.
//
// Handshake: the in_* fields are meaningful only while in_valid=1. The stage
// consumes them on a rising edge where stall=0; while stall=1 upstream must
// hold every in_* field (and its PC) unchanged. wb_* fields are meaningful
// only while wb_valid=1; there is no downstream back-pressure.
interface data_mem_stage_if;
  logic        in_valid;
  logic        in_mem_read;
  logic        in_mem_write;
  logic        in_reg_write;
  logic [1:0]  in_size;
  logic        in_unsigned;
  logic [31:0] in_alu_result;
  logic [31:0] in_store_data;
  logic [4:0]  in_write_reg;
  logic        stall;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_data;
  logic        misalign;
  logic        misalign_sticky;

  modport master (
    output in_valid, in_mem_read, in_mem_write, in_reg_write, in_size,
           in_unsigned, in_alu_result, in_store_data, in_write_reg,
    input  stall, wb_valid, wb_reg_write, wb_write_reg, wb_data,
           misalign, misalign_sticky
  );

  modport slave (
    input  in_valid, in_mem_read, in_mem_write, in_reg_write, in_size,
           in_unsigned, in_alu_result, in_store_data, in_write_reg,
    output stall, wb_valid, wb_reg_write, wb_write_reg, wb_data,
           misalign, misalign_sticky
  );
endinterface

// File: rtl/data_mem_stage_byte_mem.sv
// Byte-wide data memory: four consecutive bytes read asynchronously from
// addr (wrapping at the top), written per byte lane on the rising edge.
// Lane 0 is the byte at addr and sits in bits [31:24] (big-endian).
module byte_mem #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        we,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [7:0]        memory [DEPTH];
  logic [ADDR_W-1:0] lane_addr [4];

  // Byte address of each lane, wrapping modulo the memory size.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane_addr[i] = addr + ADDR_W'(i);
    end
  end

  // Asynchronous four-byte read, lane 0 in the most significant byte.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < 4; i++) begin
      rdata[31-8*i -: 8] = memory[lane_addr[i]];
    end
  end

  // Per-lane byte write; contents survive reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) memory[lane_addr[i]] <= wdata[31-8*i -: 8];
    end
  end

endmodule

// File: rtl/data_mem_stage.sv
// MEM stage of a MIPS-style pipeline: performs loads/stores against a
// byte-addressed memory with WAIT_CYC stall cycles per aligned access,
// flags misaligned accesses, and loads the MEM/WB register.
module data_mem_stage
  import mips_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int WAIT_CYC = WAIT_CYC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  data_mem_stage_if.slave   bus,
  output state_t            dbg_state
);

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYC);
  localparam bit         HAS_WAIT  = (WAIT_CYC != 0);

  state_t            state, state_nx;
  logic [3:0]        cnt, cnt_nx;
  logic              stall, complete;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        size_eff;
  logic              mem_op, misaligned_op, aligned_op;
  logic [3:0]        lanes, we;
  logic [31:0]       wdata, rdata, load_data;
  logic              wb_valid_q, wb_reg_write_q, misalign_q, sticky_q;
  logic [4:0]        wb_write_reg_q;
  logic [31:0]       wb_data_q;

  assign addr          = bus.in_alu_result[ADDR_W-1:0];
  assign size_eff      = (bus.in_size == SIZE_ILLEGAL) ? SIZE_WORD : bus.in_size;
  assign mem_op        = bus.in_valid & (bus.in_mem_read | bus.in_mem_write);
  assign misaligned_op = mem_op & is_misaligned(size_eff, bus.in_alu_result[1:0]);
  assign aligned_op    = mem_op & ~misaligned_op;

  // State register and wait counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next state: IDLE counts as the first stall cycle, ACCESS finishes the rest.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ST_IDLE: begin
        if (aligned_op && HAS_WAIT) begin
          state_nx = ST_ACCESS;
          cnt_nx   = 4'd1;
        end
      end
      ST_ACCESS: begin
        if (cnt == WAIT_LAST) begin
          state_nx = ST_IDLE;
          cnt_nx   = 4'd0;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = 4'd0;
      end
    endcase
  end

  // Outputs of the FSM: stall while waiting, complete on the final cycle.
  always_comb begin
    stall    = 1'b0;
    complete = 1'b0;
    if (rst_n) begin
      case (state)
        ST_IDLE: begin
          if (aligned_op) begin
            if (HAS_WAIT) stall    = 1'b1;
            else          complete = 1'b1;
          end
        end
        ST_ACCESS: begin
          if (cnt == WAIT_LAST) complete = 1'b1;
          else                  stall    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Store lane selection and big-endian data placement.
  always_comb begin
    case (size_eff)
      SIZE_BYTE: begin
        lanes = 4'b0001;
        wdata = {bus.in_store_data[7:0], 24'h0};
      end
      SIZE_HALF: begin
        lanes = 4'b0011;
        wdata = {bus.in_store_data[15:0], 16'h0};
      end
      default: begin
        lanes = 4'b1111;
        wdata = bus.in_store_data;
      end
    endcase
    we = (complete && bus.in_mem_write) ? lanes : 4'b0000;
  end

  // Load extraction with sign or zero extension.
  always_comb begin
    case (size_eff)
      SIZE_BYTE: load_data = {{24{~bus.in_unsigned & rdata[31]}}, rdata[31:24]};
      SIZE_HALF: load_data = {{16{~bus.in_unsigned & rdata[31]}}, rdata[31:16]};
      default:   load_data = rdata;
    endcase
  end

  byte_mem #(.ADDR_W(ADDR_W)) DM (
    .clk   (clk),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata)
  );

  // MEM/WB register: bubble while stalled or idle, misalign flags on bad access.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_write_reg_q <= 5'd0;
      wb_data_q      <= 32'd0;
      misalign_q     <= 1'b0;
      sticky_q       <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      if (stall || !bus.in_valid) begin
        wb_valid_q     <= 1'b0;
        wb_reg_write_q <= 1'b0;
      end else begin
        wb_valid_q     <= 1'b1;
        wb_write_reg_q <= bus.in_write_reg;
        wb_reg_write_q <= bus.in_reg_write & (|bus.in_write_reg) & ~misaligned_op;
        wb_data_q      <= (complete && bus.in_mem_read && !bus.in_mem_write)
                          ? load_data : bus.in_alu_result;
        if (misaligned_op) begin
          misalign_q <= 1'b1;
          sticky_q   <= 1'b1;
        end
      end
    end
  end

  assign bus.stall           = stall;
  assign bus.wb_valid        = wb_valid_q;
  assign bus.wb_reg_write    = wb_reg_write_q;
  assign bus.wb_write_reg    = wb_write_reg_q;
  assign bus.wb_data         = wb_data_q;
  assign bus.misalign        = misalign_q;
  assign bus.misalign_sticky = sticky_q;
  assign dbg_state           = state;

endmodule

// File: tb/tb_data_mem_stage.sv
// Directed bench for data_mem_stage: a byte-array reference model predicts
// stall length and the MEM/WB result of each instruction; a compare process
// checks the MEM/WB register after each completion, and literal checks pin
// the hand-computed cases.
module tb_data_mem_stage;
  import mips_pkg::*;

  localparam int AW   = 8;
  localparam int WAIT = 2;

  typedef struct packed {
    logic        valid;
    logic        rw;
    logic [4:0]  wreg;
    logic [31:0] data;
    logic        chk_data;
    logic        mis;
  } wb_t;

  logic   clk;
  logic   rst_n;
  state_t dut_state;

  data_mem_stage_if bus ();

  data_mem_stage #(.ADDR_W(AW), .WAIT_CYC(WAIT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dut_state)
  );

  int   n_vec = 0;
  int   n_err = 0;
  wb_t  exp_q[$];
  wb_t  ce;
  logic [7:0] mem_model [2**AW];

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: what the stage must produce for one instruction, and
  // how many stall cycles it must cost. Updates the model memory on stores.
  task automatic model_step(input logic vld, rd, wr, rw, input logic [1:0] sz,
                            input logic uns, input logic [31:0] alu, sd,
                            input logic [4:0] wreg, output wb_t e, output int n_stall);
    int          a, nb;
    logic [31:0] v, mask;
    e       = '0;
    n_stall = 0;
    a       = int'(alu % (2**AW));
    nb      = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    if (!vld) return;
    e.valid = 1'b1;
    e.wreg  = wreg;
    if ((rd || wr) && (a % nb) != 0) begin
      e.mis = 1'b1;
      return;
    end
    e.chk_data = 1'b1;
    e.rw       = rw && (wreg != 5'd0);
    e.data     = alu;
    if (rd || wr) n_stall = WAIT;
    if (wr) begin
      for (int i = 0; i < nb; i++)
        mem_model[(a + i) % (2**AW)] = 8'(sd >> (8 * (nb - 1 - i)));
    end else if (rd) begin
      v = 32'd0;
      for (int i = 0; i < nb; i++) v = (v << 8) | 32'(mem_model[(a + i) % (2**AW)]);
      if (nb < 4 && !uns && v[8*nb-1]) begin
        mask = (32'h1 << (8 * nb)) - 32'd1;
        v    = v | ~mask;
      end
      e.data = v;
    end
  endtask

  task automatic idle();
    bus.in_valid      = 1'b0;
    bus.in_mem_read   = 1'b0;
    bus.in_mem_write  = 1'b0;
    bus.in_reg_write  = 1'b0;
    bus.in_size       = 2'd0;
    bus.in_unsigned   = 1'b0;
    bus.in_alu_result = 32'd0;
    bus.in_store_data = 32'd0;
    bus.in_write_reg  = 5'd0;
  endtask

  // Drive one instruction from a falling edge, check the stall window, and
  // return just after the edge that loads MEM/WB.
  task automatic issue(input logic rd, wr, rw, input logic [1:0] sz, input logic uns,
                       input logic [31:0] alu, sd, input logic [4:0] wreg,
                       input logic vld = 1'b1);
    wb_t e;
    int  n;
    @(negedge clk);
    bus.in_valid      = vld;
    bus.in_mem_read   = rd;
    bus.in_mem_write  = wr;
    bus.in_reg_write  = rw;
    bus.in_size       = sz;
    bus.in_unsigned   = uns;
    bus.in_alu_result = alu;
    bus.in_store_data = sd;
    bus.in_write_reg  = wreg;
    model_step(vld, rd, wr, rw, sz, uns, alu, sd, wreg, e, n);
    #1;
    for (int k = 0; k < n; k++) begin
      chk("stall_high", 32'(bus.stall), 32'd1);
      if (k > 0) chk("bubble", 32'(bus.wb_valid), 32'd0);
      @(negedge clk);
      #1;
    end
    chk("stall_low", 32'(bus.stall), 32'd0);
    if (n > 0) chk("bubble_end", 32'(bus.wb_valid), 32'd0);
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  // Compare process: MEM/WB against the model after every completion edge.
  always begin
    @(negedge clk);
    if (exp_q.size() > 0) begin
      ce = exp_q.pop_front();
      chk("wb_valid", 32'(bus.wb_valid), 32'(ce.valid));
      chk("wb_reg_write", 32'(bus.wb_reg_write), 32'(ce.rw));
      chk("misalign", 32'(bus.misalign), 32'(ce.mis));
      if (ce.valid) chk("wb_write_reg", 32'(bus.wb_write_reg), 32'(ce.wreg));
      if (ce.valid && ce.chk_data) chk("wb_data", bus.wb_data, ce.data);
    end
  end

  initial begin
    for (int i = 0; i < 2**AW; i++) mem_model[i] = 8'h00;
    idle();
    rst_n = 1'b0;
    // An aligned store presented during reset must not stall.
    @(negedge clk);
    bus.in_valid      = 1'b1;
    bus.in_mem_write  = 1'b1;
    bus.in_size       = SIZE_WORD;
    bus.in_alu_result = 32'd0;
    #1 chk("rst_stall", 32'(bus.stall), 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst_wb_reg_write", 32'(bus.wb_reg_write), 32'd0);
    chk("rst_wb_write_reg", 32'(bus.wb_write_reg), 32'd0);
    chk("rst_wb_data", bus.wb_data, 32'd0);
    chk("rst_misalign", 32'(bus.misalign), 32'd0);
    chk("rst_sticky", 32'(bus.misalign_sticky), 32'd0);
    chk("rst_state", 32'(dut_state), 32'(ST_IDLE));
    idle();
    rst_n = 1'b1;

    // ADD 37 to $t0, then a write to $0.
    issue(1'b0, 1'b0, 1'b1, SIZE_WORD, 1'b0, 32'd37, 32'd0, 5'd8);
    #1 chk("add_data", bus.wb_data, 32'd37);
    chk("add_rw", 32'(bus.wb_reg_write), 32'd1);
    issue(1'b0, 1'b0, 1'b1, SIZE_WORD, 1'b0, 32'd99, 32'd0, 5'd0);
    #1 chk("zero_reg_rw", 32'(bus.wb_reg_write), 32'd0);

    // SW 0x11223344 to addr 4.
    issue(1'b0, 1'b1, 1'b0, SIZE_WORD, 1'b0, 32'd4, 32'h11223344, 5'd0);
    #1 chk("sw_mem4", 32'(dut.DM.memory[4]), 32'h11);
    chk("sw_mem5", 32'(dut.DM.memory[5]), 32'h22);
    chk("sw_mem6", 32'(dut.DM.memory[6]), 32'h33);
    chk("sw_mem7", 32'(dut.DM.memory[7]), 32'h44);
    chk("sw_rw", 32'(bus.wb_reg_write), 32'd0);

    // Loads after the store.
    issue(1'b1, 1'b0, 1'b1, SIZE_BYTE, 1'b0, 32'd7, 32'd0, 5'd9);
    #1 chk("lb7", bus.wb_data, 32'h00000044);
    issue(1'b1, 1'b0, 1'b1, SIZE_HALF, 1'b1, 32'd4, 32'd0, 5'd10);
    #1 chk("lhu4", bus.wb_data, 32'h00001122);
    issue(1'b0, 1'b1, 1'b0, SIZE_BYTE, 1'b0, 32'd10, 32'h12345680, 5'd0);
    issue(1'b1, 1'b0, 1'b1, SIZE_BYTE, 1'b0, 32'd10, 32'd0, 5'd11);
    #1 chk("lb_neg", bus.wb_data, 32'hFFFFFF80);
    issue(1'b1, 1'b0, 1'b1, SIZE_BYTE, 1'b1, 32'd10, 32'd0, 5'd11);
    issue(1'b1, 1'b0, 1'b1, SIZE_HALF, 1'b0, 32'd6, 32'd0, 5'd12);
    issue(1'b1, 1'b0, 1'b1, SIZE_WORD, 1'b0, 32'd4, 32'd0, 5'd13);
    issue(1'b1, 1'b0, 1'b1, SIZE_ILLEGAL, 1'b0, 32'd4, 32'd0, 5'd14);

    // Misaligned LW and SW at addr 6.
    issue(1'b1, 1'b0, 1'b1, SIZE_WORD, 1'b0, 32'd6, 32'd0, 5'd15);
    #1 chk("mis_pulse", 32'(bus.misalign), 32'd1);
    chk("mis_sticky", 32'(bus.misalign_sticky), 32'd1);
    chk("mis_rw", 32'(bus.wb_reg_write), 32'd0);
    chk("mis_valid", 32'(bus.wb_valid), 32'd1);
    issue(1'b0, 1'b1, 1'b0, SIZE_WORD, 1'b0, 32'd6, 32'hFFFFFFFF, 5'd0);
    #1 chk("mis_mem6", 32'(dut.DM.memory[6]), 32'h33);
    chk("mis_mem7", 32'(dut.DM.memory[7]), 32'h44);
    issue(1'b0, 1'b1, 1'b0, SIZE_HALF, 1'b0, 32'd5, 32'hAAAA, 5'd0);
    issue(1'b0, 1'b0, 1'b1, SIZE_WORD, 1'b0, 32'd1, 32'd0, 5'd3);
    #1 chk("mis_pulse_end", 32'(bus.misalign), 32'd0);
    chk("sticky_held", 32'(bus.misalign_sticky), 32'd1);

    // Read and write together, then store-then-load to the same word.
    issue(1'b1, 1'b1, 1'b1, SIZE_WORD, 1'b0, 32'd12, 32'hCAFEF00D, 5'd16);
    #1 chk("rdwr_data", bus.wb_data, 32'd12);
    issue(1'b1, 1'b0, 1'b1, SIZE_WORD, 1'b0, 32'd12, 32'd0, 5'd17);
    #1 chk("st_ld", bus.wb_data, 32'hCAFEF00D);

    // Invalid slot, halfword with wrapped address.
    issue(1'b1, 1'b0, 1'b1, SIZE_WORD, 1'b0, 32'd12, 32'd0, 5'd18, 1'b0);
    #1 chk("invalid_wb", 32'(bus.wb_valid), 32'd0);
    issue(1'b0, 1'b1, 1'b0, SIZE_HALF, 1'b0, 32'h00000102, 32'h0000BEEF, 5'd0);
    issue(1'b1, 1'b0, 1'b1, SIZE_HALF, 1'b0, 32'd2, 32'd0, 5'd19);
    #1 chk("lh_beef", bus.wb_data, 32'hFFFFBEEF);

    // Reset in the second stall cycle of SW 0xDEADBEEF to addr 8.
    issue(1'b0, 1'b1, 1'b0, SIZE_WORD, 1'b0, 32'd8, 32'hA5A5A5A5, 5'd0);
    @(negedge clk);
    bus.in_valid      = 1'b1;
    bus.in_mem_write  = 1'b1;
    bus.in_size       = SIZE_WORD;
    bus.in_alu_result = 32'd8;
    bus.in_store_data = 32'hDEADBEEF;
    #1 chk("abort_stall1", 32'(bus.stall), 32'd1);
    @(negedge clk);
    #1 chk("abort_stall2", 32'(bus.stall), 32'd1);
    rst_n = 1'b0;
    #1 chk("abort_stall_rst", 32'(bus.stall), 32'd0);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    #1 chk("abort_stall_after", 32'(bus.stall), 32'd0);
    chk("abort_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("abort_sticky", 32'(bus.misalign_sticky), 32'd0);
    chk("abort_state", 32'(dut_state), 32'(ST_IDLE));
    for (int i = 8; i < 12; i++) begin
      chk("abort_mem", 32'(dut.DM.memory[i]), 32'hA5);
    end
    issue(1'b1, 1'b0, 1'b1, SIZE_WORD, 1'b0, 32'd8, 32'd0, 5'd20);

    // Address upper bits ignored: 0x104 lands at byte 4.
    issue(1'b0, 1'b1, 1'b0, SIZE_BYTE, 1'b0, 32'h00000104, 32'h0000005A, 5'd0);
    #1 chk("wrap_mem4", 32'(dut.DM.memory[4]), 32'h5A);
    issue(1'b1, 1'b0, 1'b1, SIZE_WORD, 1'b1, 32'h00000104, 32'd0, 5'd21);
    #1 chk("wrap_lw", bus.wb_data, 32'h5A223344);

    idle();
    @(negedge clk);
    #1 chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_mem_stage.md
DATA_MEM_STAGE -- requirements
Module: data_mem_stage

Interface
REQ-001 Parameter ADDR_W, default 8, byte-address width; memory holds 2**ADDR_W bytes.
REQ-002 Parameter WAIT_CYC, default 2, extra wait cycles per aligned memory access; legal range 0..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; one clock, reset is synchronous and active-low.
REQ-005 in_valid  input  1  EX/MEM holds a live instruction.
REQ-006 in_mem_read, in_mem_write, in_reg_write  input  1 each  EX/MEM control bits.
REQ-007 in_size  input  2  0=byte, 1=half, 2=word; 3 is illegal and treated as word.
REQ-008 in_unsigned  input  1  zero-extend loads when 1, sign-extend when 0.
REQ-009 in_alu_result  input  32  effective address, or the result for non-memory ops.
REQ-010 in_store_data  input  32  store operand (rt).
REQ-011 in_write_reg  input  5  destination register.
REQ-012 stall  output  1  upstream holds EX/MEM and PC while high.
REQ-013 wb_valid, wb_reg_write  output  1 each  MEM/WB register.
REQ-014 wb_write_reg  output  5; wb_data  output  32  the value to write back (load data or ALU result).
REQ-015 misalign  output  1  one-cycle pulse; misalign_sticky  output  1  latched until reset.

Function
REQ-016 FSM states: IDLE and ACCESS; a 4-bit wait counter is used in ACCESS.
REQ-017 Non-memory op (valid, no read or write) in IDLE: MEM/WB loads on the next edge; wb_data = in_alu_result; stall stays 0.
REQ-018 Aligned memory op in IDLE with WAIT_CYC>0: stall is asserted combinationally in that cycle; FSM enters ACCESS.
REQ-019 Stall is high for exactly WAIT_CYC consecutive cycles. Memory write/read and the MEM/WB update occur on the edge ending the first cycle with stall=0.
REQ-020 While stall is high, wb_valid = 0 (bubble) and the inputs are held stable by upstream.
REQ-021 With WAIT_CYC=0, a memory op completes with 1-cycle latency, the same as REQ-017.
REQ-022 Byte order is big-endian. SB writes addr←data[7:0]. SH writes addr←[15:8] and addr+1←[7:0]. SW writes addr..addr+3, MSB first.
REQ-023 Loads assemble bytes in the same order. LB/LH extend per in_unsigned; LW is unchanged.
REQ-024 The address is taken modulo 2**ADDR_W; upper bits are ignored.
REQ-025 Misaligned access (half with addr[0]=1, or word with addr[1:0]≠0):
- no stall, no memory write, wb_reg_write=0, wb_valid=1;
- misalign pulses for 1 cycle;
- misalign_sticky is set.
REQ-026 mem_read and mem_write both high: the store is performed, the load is suppressed, and wb_data = in_alu_result.
REQ-027 in_write_reg=0 forces wb_reg_write=0.
REQ-028 in_valid=0: no memory access; wb_valid=0 on the next edge.
REQ-029 A store followed by a load to the same address in the next instruction: the load returns the newly stored data.

Reset
REQ-030 With rst_n=0 at an edge: state=IDLE, counter=0, and wb_valid, wb_reg_write, wb_write_reg, wb_data, misalign and misalign_sticky are all 0.
REQ-031 stall is forced to 0 while rst_n=0.
REQ-032 Reset during ACCESS aborts the access: no memory write, no writeback.
REQ-033 Memory contents are not cleared by reset.

Structure
REQ-034 Shared package mips_pkg holds the in_size encodings, the FSM state enum and the WAIT_CYC default.
REQ-035 Sub-module byte_mem: a 2**ADDR_W x 8 array named memory, with async read of 4 bytes and a per-byte write enable. Instance name DM, so benches can preload and poke DM.memory[n].

Verification
REQ-036 WAIT_CYC=2: SW 0x11223344 to addr 4 → stall high 2 cycles; memory[4..7]=11,22,33,44; wb_reg_write=0.
REQ-037 After REQ-036: LB addr 7 signed → wb_data=0x00000044. LH addr 4 unsigned → 0x00001122. Byte 0x80 via LB signed → 0xFFFFFF80.
REQ-038 LW addr 6 → misalign pulse, sticky=1, stall=0, memory unchanged, wb_reg_write=0.
REQ-039 Reset asserted in the second stall cycle of SW 0xDEADBEEF to addr 8 → memory[8..11] unchanged, wb_valid=0, stall=0 next cycle.
REQ-040 Address 0x00000104 with ADDR_W=8 → the access lands at byte 4.
REQ-041 ADD result 37 to $t0 with WAIT_CYC=2 → wb_data=37 one cycle later, no stall. Write to $0 → wb_reg_write=0.
